// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment scan bus: rebuilds one hex frame per full scan.
// Optional build macro SEG_DEC_CHANGE_ONLY_EN: o_valid pulses only when the completed frame differs.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYC    = 4,
  parameter int FRAME_TIMEOUT = 1048576
) (
  input  logic                    clk_gl,
  input  logic                    rst,
  input  logic [7:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_sel,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic                    o_valid,
  output logic                    o_err,
  output logic                    o_timeout
);

  localparam int SW   = $clog2(STABLE_CYC + 1);
  localparam int IW   = $clog2(FRAME_TIMEOUT + 1);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, HELD = 2'd2} state_t;

  // Returns {valid, nibble}; only the seven segment lines take part, DP is ignored.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'h00;
    case (pat)
      7'h40:   res = {1'b1, 4'h0};
      7'h79:   res = {1'b1, 4'h1};
      7'h24:   res = {1'b1, 4'h2};
      7'h30:   res = {1'b1, 4'h3};
      7'h19:   res = {1'b1, 4'h4};
      7'h12:   res = {1'b1, 4'h5};
      7'h02:   res = {1'b1, 4'h6};
      7'h78:   res = {1'b1, 4'h7};
      7'h00:   res = {1'b1, 4'h8};
      7'h10:   res = {1'b1, 4'h9};
      7'h08:   res = {1'b1, 4'hA};
      7'h03:   res = {1'b1, 4'hB};
      7'h46:   res = {1'b1, 4'hC};
      7'h21:   res = {1'b1, 4'hD};
      7'h06:   res = {1'b1, 4'hE};
      7'h0E:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  function automatic logic [IDXW-1:0] low_index(input logic [NUM_DIGITS-1:0] low);
    logic [IDXW-1:0] idx;
    idx = {IDXW{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (low[k]) idx = IDXW'(k);
    end
    return idx;
  endfunction

  logic [7:0]              seg_q1_r, seg_q2_r, seg_prev_r;
  logic [NUM_DIGITS-1:0]   sel_q1_r, sel_q2_r, sel_prev_r;
  logic [SW-1:0]           stab_cnt_r, stab_nxt_s;
  logic [IW-1:0]           idle_cnt_r, idle_nxt_s;
  state_t                  state_r, state_nxt_s;
  logic                    changed_s, accept_s, capture_s, multi_s, single_s;
  logic                    complete_s, timeout_hit_s, pulse_s;
  logic [NUM_DIGITS-1:0]   sel_low_s, seen_r, seen_nxt_s, dp_sh_r, dp_nxt_s;
  logic [IDXW-1:0]         idx_s;
  logic [4:0]              dec_s;
  logic [4*NUM_DIGITS-1:0] shadow_r, shadow_nxt_s;
  logic                    frame_err_r, err_nxt_s;
  logic [4*NUM_DIGITS-1:0] value_r;
  logic [NUM_DIGITS-1:0]   dp_r;
  logic                    valid_r, err_r, timeout_r;
`ifdef SEG_DEC_CHANGE_ONLY_EN
  logic                    first_done_r;
`endif

  // Two-stage input synchronizer plus the previous stage-2 sample for change detection.
  always_ff @(posedge clk_gl or negedge rst) begin
    if (!rst) begin
      seg_q1_r   <= 8'h00;
      seg_q2_r   <= 8'h00;
      seg_prev_r <= 8'h00;
      sel_q1_r   <= {NUM_DIGITS{1'b0}};
      sel_q2_r   <= {NUM_DIGITS{1'b0}};
      sel_prev_r <= {NUM_DIGITS{1'b0}};
    end else begin
      seg_q1_r   <= i_seg;
      seg_q2_r   <= seg_q1_r;
      seg_prev_r <= seg_q2_r;
      sel_q1_r   <= i_sel;
      sel_q2_r   <= sel_q1_r;
      sel_prev_r <= sel_q2_r;
    end
  end

  // Stability counting and dwell FSM next state; accept fires once when a dwell becomes stable.
  always_comb begin
    changed_s   = (seg_q2_r != seg_prev_r) || (sel_q2_r != sel_prev_r);
    stab_nxt_s  = stab_cnt_r;
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    if (changed_s) begin
      stab_nxt_s = {SW{1'b0}};
    end else if (stab_cnt_r < SW'(STABLE_CYC - 1)) begin
      stab_nxt_s = stab_cnt_r + SW'(1);
    end else begin
      stab_nxt_s = stab_cnt_r;
    end
    case (state_r)
      IDLE: begin
        if (changed_s) state_nxt_s = DWELL;
        else           state_nxt_s = IDLE;
      end
      DWELL: begin
        if (changed_s) begin
          state_nxt_s = DWELL;
        end else if (stab_nxt_s == SW'(STABLE_CYC - 1)) begin
          state_nxt_s = HELD;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = DWELL;
        end
      end
      HELD: begin
        if (changed_s) state_nxt_s = DWELL;
        else           state_nxt_s = HELD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Accept classification, shadow/seen update and frame completion detect.
  always_comb begin
    sel_low_s    = ~sel_q2_r;
    multi_s      = |(sel_low_s & (sel_low_s - NUM_DIGITS'(1)));
    single_s     = (|sel_low_s) & ~multi_s;
    idx_s        = low_index(sel_low_s);
    dec_s        = decode_seg(seg_q2_r[6:0]);
    capture_s    = accept_s & single_s;
    shadow_nxt_s = shadow_r;
    dp_nxt_s     = dp_sh_r;
    seen_nxt_s   = seen_r;
    err_nxt_s    = frame_err_r;
    if (capture_s) begin
      shadow_nxt_s[idx_s*4 +: 4] = dec_s[3:0];
      dp_nxt_s[idx_s]            = ~seg_q2_r[7];
      seen_nxt_s[idx_s]          = 1'b1;
      err_nxt_s                  = frame_err_r | ~dec_s[4];
    end else if (accept_s && multi_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = frame_err_r;
    end
    complete_s    = capture_s && (seen_nxt_s == {NUM_DIGITS{1'b1}});
    timeout_hit_s = (idle_cnt_r == IW'(FRAME_TIMEOUT));
    if (capture_s)          idle_nxt_s = {IW{1'b0}};
    else if (timeout_hit_s) idle_nxt_s = idle_cnt_r;
    else                    idle_nxt_s = idle_cnt_r + IW'(1);
`ifdef SEG_DEC_CHANGE_ONLY_EN
    pulse_s = ~first_done_r || ({dp_nxt_s, shadow_nxt_s, err_nxt_s} != {dp_r, value_r, err_r});
`else
    pulse_s = 1'b1;
`endif
  end

  // Dwell FSM, stability and idle counters.
  always_ff @(posedge clk_gl or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      stab_cnt_r <= {SW{1'b0}};
      idle_cnt_r <= {IW{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      stab_cnt_r <= stab_nxt_s;
      idle_cnt_r <= idle_nxt_s;
      timeout_r  <= (idle_nxt_s == IW'(FRAME_TIMEOUT));
    end
  end

  // Frame assembly; a timeout discards the partial frame but keeps the last published one.
  always_ff @(posedge clk_gl or negedge rst) begin
    if (!rst) begin
      shadow_r    <= {(4*NUM_DIGITS){1'b0}};
      dp_sh_r     <= {NUM_DIGITS{1'b0}};
      seen_r      <= {NUM_DIGITS{1'b0}};
      frame_err_r <= 1'b0;
      value_r     <= {(4*NUM_DIGITS){1'b0}};
      dp_r        <= {NUM_DIGITS{1'b0}};
      err_r       <= 1'b0;
      valid_r     <= 1'b0;
`ifdef SEG_DEC_CHANGE_ONLY_EN
      first_done_r <= 1'b0;
`endif
    end else begin
      shadow_r <= shadow_nxt_s;
      dp_sh_r  <= dp_nxt_s;
      if (complete_s) begin
        seen_r      <= {NUM_DIGITS{1'b0}};
        frame_err_r <= 1'b0;
        value_r     <= shadow_nxt_s;
        dp_r        <= dp_nxt_s;
        err_r       <= err_nxt_s;
        valid_r     <= pulse_s;
`ifdef SEG_DEC_CHANGE_ONLY_EN
        first_done_r <= 1'b1;
`endif
      end else if (timeout_hit_s && !capture_s) begin
        seen_r      <= {NUM_DIGITS{1'b0}};
        frame_err_r <= 1'b0;
        valid_r     <= 1'b0;
      end else begin
        seen_r      <= seen_nxt_s;
        frame_err_r <= err_nxt_s;
        valid_r     <= 1'b0;
      end
    end
  end

  assign o_value   = value_r;
  assign o_dp      = dp_r;
  assign o_valid   = valid_r;
  assign o_err     = err_r;
  assign o_timeout = timeout_r;

endmodule
